// File: rtl/phase_timing_pkg.sv
// Shared types and helpers for the N-phase timing generator.
package phase_timing_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  // Index width for n phases; never narrower than one bit.
  function automatic int phase_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/req_sync_chan.sv
// One request channel: synchronise, detect rising edge, queue it as pending,
// arm it for one full cycle and flag requests lost while one is still queued.
module req_sync_chan (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic start,
  input  logic idle,
  input  logic hit_a,
  input  logic hit_b,
  input  logic ovr_clr,
  output logic sync_a,
  output logic sync_b,
  output logic overrun
);

  logic s1, s2, s3, edge_q, pending, armed, armed_d;

  // start marks the edge that enters phase 0, so armed lines up with the cycle.
  always_comb armed_d = idle ? 1'b0 : (start ? pending : armed);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      edge_q  <= 1'b0;
      pending <= 1'b0;
      armed   <= 1'b0;
      overrun <= 1'b0;
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
    end else begin
      s1     <= req;
      s2     <= s1;
      s3     <= s2;
      edge_q <= s2 & ~s3;
      armed  <= armed_d;
      if (start)       pending <= edge_q;
      else if (edge_q) pending <= 1'b1;
      // A new overrun wins over a coincident clear.
      if (edge_q && pending && !start) overrun <= 1'b1;
      else if (ovr_clr)                overrun <= 1'b0;
      sync_a <= armed_d & hit_a;
      sync_b <= armed_d & hit_b;
    end
  end

endmodule

// File: rtl/phase_timing_gen.sv
// N-phase one-hot timing generator with programmable ticks-per-phase,
// clean start/stop and per-channel request re-timing onto two phases.
module phase_timing_gen
  import phase_timing_pkg::*;
#(
  parameter int NUM_PHASES   = 4,
  parameter int NUM_CHAN     = 1,
  parameter int DIV_W        = 8,
  parameter int SYNC_A_PHASE = 1,
  parameter int SYNC_B_PHASE = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick_in,
  input  logic                  enable,
  input  logic [DIV_W-1:0]      div_ratio,
  input  logic [NUM_CHAN-1:0]   req_in,
  input  logic                  ovr_clr,
  output logic [NUM_PHASES-1:0] phase_oh,
  output logic [phase_w(NUM_PHASES)-1:0] phase_idx,
  output logic                  cycle_start,
  output logic                  half_rate,
  output logic                  running,
  output logic [NUM_CHAN-1:0]   sync_a,
  output logic [NUM_CHAN-1:0]   sync_b,
  output logic [NUM_CHAN-1:0]   overrun
);

  localparam int PW = phase_w(NUM_PHASES);

  state_t                  state, state_d;
  logic [PW-1:0]           idx_d;
  logic [DIV_W-1:0]        cnt, cnt_d, shadow, shadow_d, div_fix;
  logic                    adv, last, start, run_d, toggle;
  logic                    hit_a, hit_b;
  logic [NUM_PHASES-1:0]   oh_d;

  assign div_fix = (div_ratio == '0) ? DIV_W'(1) : div_ratio;
  assign adv     = tick_in && (cnt == shadow - DIV_W'(1));
  assign last    = (phase_idx == PW'(NUM_PHASES - 1));

  always_comb begin
    state_d  = state;
    idx_d    = phase_idx;
    cnt_d    = cnt;
    shadow_d = shadow;
    start    = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_d  = RUN;
          idx_d    = '0;
          cnt_d    = '0;
          shadow_d = div_fix;
          start    = 1'b1;
        end
      end
      RUN, STOP: begin
        if (state == RUN && !enable)     state_d = STOP;
        else if (state == STOP && enable) state_d = RUN;
        if (adv) begin
          cnt_d    = '0;
          shadow_d = div_fix;
          if (!last) begin
            idx_d = phase_idx + PW'(1);
          end else begin
            idx_d = '0;
            // A stop request finishes the current cycle, then parks in IDLE.
            if (state == STOP && !enable) state_d = IDLE;
            else                          start   = 1'b1;
          end
        end else if (tick_in) begin
          cnt_d = cnt + DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign run_d = (state_d != IDLE);
  assign hit_a = run_d && (idx_d == PW'(SYNC_A_PHASE));
  assign hit_b = run_d && (idx_d == PW'(SYNC_B_PHASE));

  always_comb begin
    oh_d = '0;
    for (int p = 0; p < NUM_PHASES; p++) oh_d[p] = run_d && (idx_d == PW'(p));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      phase_idx   <= '0;
      phase_oh    <= '0;
      cnt         <= '0;
      shadow      <= DIV_W'(1);
      toggle      <= 1'b0;
      cycle_start <= 1'b0;
      half_rate   <= 1'b0;
      running     <= 1'b0;
    end else begin
      state       <= state_d;
      phase_idx   <= idx_d;
      phase_oh    <= oh_d;
      cnt         <= cnt_d;
      shadow      <= shadow_d;
      toggle      <= toggle ^ start;
      cycle_start <= start;
      half_rate   <= start & toggle;
      running     <= run_d;
    end
  end

  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
    req_sync_chan u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_in[c]),
      .start   (start),
      .idle    (!run_d),
      .hit_a   (hit_a),
      .hit_b   (hit_b),
      .ovr_clr (ovr_clr),
      .sync_a  (sync_a[c]),
      .sync_b  (sync_b[c]),
      .overrun (overrun[c])
    );
  end

endmodule

// File: doc/phase_timing_gen.md
Name: phase_timing_gen

Overview:
- Parametrised successor to the CDU fixed 4-phase digital-mode timing generator.
- Derives an N-phase one-hot phase sequence from a base-rate tick strobe, with a programmable ticks-per-phase divider and clean start/stop.
- Adds NUM_CHAN request synchronisers. Each re-times an asynchronous request (ISSI-style) onto two selectable phases of the next full cycle.
- Feeds phase drivers and interrupt-sync logic in the CDU digital section.

Parameters:
- NUM_PHASES, 4: phases per cycle; must be >=2.
- NUM_CHAN, 1: independent request-sync channels; must be >=1.
- DIV_W, 8: width of div_ratio.
- SYNC_A_PHASE, 1: phase index driving sync_a; must be <NUM_PHASES.
- SYNC_B_PHASE, 2: phase index driving sync_b; must be <NUM_PHASES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- tick_in  in  1  base-rate strobe, one clk wide (51 kHz-class)
- enable  in  1  run request
- div_ratio  in  DIV_W  ticks per phase; 0 treated as 1
- req_in  in  NUM_CHAN  asynchronous request levels
- ovr_clr  in  1  clears all overrun flags
- phase_oh  out  NUM_PHASES  one-hot active phase, all-zero when idle
- phase_idx  out  $clog2(NUM_PHASES)  active phase index
- cycle_start  out  1  one-clk pulse on entry to phase 0
- half_rate  out  1  one-clk pulse on every second cycle_start (25 kHz-class)
- running  out  1  high in RUN/STOP
- sync_a  out  NUM_CHAN  high for the whole of phase SYNC_A_PHASE in an armed cycle
- sync_b  out  NUM_CHAN  high for the whole of phase SYNC_B_PHASE in an armed cycle
- overrun  out  NUM_CHAN  sticky lost-request flag

Behaviour:
- Reset (rst_n low at a clk edge):
  - state IDLE.
  - phase_oh=0, phase_idx=0, cycle_start=0, half_rate=0, running=0, sync_a=0, sync_b=0, overrun=0.
  - Divider count=0; half-rate toggle=0; synchroniser flops, pending and armed all 0.
  - Reset mid-cycle aborts immediately; no completion.
- FSM states: IDLE, RUN, STOP.
- IDLE -> RUN on the clk after enable=1:
  - phase_oh=1, phase_idx=0, cycle_start pulses that clk.
  - Count cleared; div_ratio latched into the shadow register (0->1).
- Phase advance (RUN):
  - Count increments on each tick_in.
  - On a tick_in with count==shadow-1: count->0, phase_idx+1, wrapping NUM_PHASES-1 -> 0.
  - The shadow register reloads from div_ratio at every phase advance. A div_ratio change mid-phase never alters the current phase length.
  - tick_in with no advance changes nothing else.
- cycle_start: one clk, on every entry to phase 0.
- half_rate: the toggle flips on each cycle_start. half_rate = cycle_start AND toggle (before the flip) → on cycle_starts 2, 4, 6…
- enable=0 in RUN -> STOP:
  - The current cycle continues.
  - At the advance out of phase NUM_PHASES-1, go to IDLE instead of phase 0. No cycle_start; outputs go to their IDLE values.
  - enable=1 again while in STOP returns to RUN with no disturbance.
- Per-channel sync:
  - Two-flop synchroniser on req_in[c], then rising-edge detect. A req_in edge registered at clk k sets pending at k+3.
  - On cycle_start: armed<=pending and pending<=0. If an edge is detected the same clk, pending<=1 (queued for the next cycle).
  - armed holds for the whole cycle; it clears at the next cycle_start or on entry to IDLE.
  - sync_a[c] = armed AND phase_idx==SYNC_A_PHASE AND running. sync_b likewise with SYNC_B_PHASE. Both are registered-equivalent and glitch-free.
  - Edge while pending=1 and no transfer that clk → overrun[c]<=1.
  - overrun clears only on ovr_clr or reset. If ovr_clr and a new overrun coincide, set wins.
  - In IDLE, edges still set pending; armed is held at 0.
- Width rules: count is DIV_W bits. Comparison uses shadow-1 in DIV_W bits; shadow is never 0.

Decomposition:
- Shared package phase_timing_pkg: state enum {IDLE,RUN,STOP}; function phase_w(n)=$clog2(n) clamped to >=1.
- One sub-module, req_sync_chan: synchroniser, edge detect, pending, armed and overrun for one channel, instantiated NUM_CHAN times via generate.

Test Plan:
- Defaults, div_ratio=1, tick_in every clk, enable=1:
  - phase_oh runs 0001,0010,0100,1000, repeating.
  - cycle_start every 4 clks.
  - half_rate every 8 clks, first at the second cycle_start.
- div_ratio=3, tick every 2nd clk, change to 1 mid-phase 2: phase 2 lasts 3 ticks, then phase 3 lasts 1 tick.
- div_ratio=0: identical to div_ratio=1.
- req_in[0] rises during phase 2:
  - sync_a[0] high for all of phase 1 of the next cycle.
  - sync_b[0] high for all of phase 2 of the next cycle.
  - Nothing in the following cycle.
- Two req_in[0] rising edges within one cycle, before the next cycle_start:
  - overrun[0]=1 and one armed cycle only.
  - ovr_clr pulse → overrun[0]=0.
- enable dropped in phase 1:
  - phases 2 and 3 complete, then phase_oh=0, running=0, no cycle_start.
- rst_n low during phase 2 with channel 0 armed: next clk all outputs 0.
- NUM_PHASES=6, NUM_CHAN=3, SYNC_A_PHASE=0, SYNC_B_PHASE=5: 6-phase sequence; independent per-channel sync pulses.
